// File: rtl/comparator_pkg.sv
// Shared binary64 field layout and helpers for the registered FP comparator.
// Field widths are fixed; the comparator is not parameterised.
package comparator_pkg;

    localparam int unsigned EXP_W    = 11;
    localparam int unsigned MAN_W    = 52;
    localparam int unsigned SIGN_BIT = 63;
    localparam logic [EXP_W-1:0] EXP_MAX = 11'h7FF;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp64_t;

    function automatic fp64_t to_fp64(input logic [63:0] raw);
        fp64_t f;
        f.sign = raw[SIGN_BIT];
        f.exp  = raw[MAN_W +: EXP_W];
        f.man  = raw[MAN_W-1:0];
        return f;
    endfunction

endpackage

// File: rtl/fp64_field_cmp.sv
// Unsigned compare of one binary64 field, yielding greater-than and equal.
// Wide fields are split into two halves so the carry chains stay short.
module fp64_field_cmp #(
    parameter int unsigned W = 11
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         eq
);

    localparam int unsigned LO_W = W / 2;
    localparam int unsigned HI_W = W - LO_W;

    logic [HI_W-1:0] a_hi, b_hi;
    logic [LO_W-1:0] a_lo, b_lo;
    logic            hi_gt, hi_eq, lo_gt, lo_eq;

    assign a_hi = a[W-1:LO_W];
    assign b_hi = b[W-1:LO_W];
    assign a_lo = a[LO_W-1:0];
    assign b_lo = b[LO_W-1:0];

    assign hi_gt = (a_hi > b_hi);
    assign hi_eq = (a_hi == b_hi);
    assign lo_gt = (a_lo > b_lo);
    assign lo_eq = (a_lo == b_lo);

    // Upper half decides unless it ties.
    assign gt = hi_gt | (hi_eq & lo_gt);
    assign eq = hi_eq & lo_eq;

endmodule

// File: rtl/comparator.sv
// Two-stage registered binary64 comparator: stage 1 classifies and compares
// fields, stage 2 resolves the priority rules into eq/lt/gt flags.
module comparator
    import comparator_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [63:0] A_64,
    input  logic [63:0] B_64,
    output logic        out_valid,
    output logic        equal_to,
    output logic        less_than,
    output logic        greater_than
);

    fp64_t op_a, op_b;
    logic  exp_gt, exp_eq, man_gt, man_eq;
    logic  nonfinite, zero_exp;

    assign op_a = to_fp64(A_64);
    assign op_b = to_fp64(B_64);

    assign nonfinite = (op_a.exp == EXP_MAX) || (op_b.exp == EXP_MAX);
    assign zero_exp  = (op_a.exp == '0) || (op_b.exp == '0);

    fp64_field_cmp #(.W(EXP_W)) u_exp_cmp (
        .a  (op_a.exp),
        .b  (op_b.exp),
        .gt (exp_gt),
        .eq (exp_eq)
    );

    fp64_field_cmp #(.W(MAN_W)) u_man_cmp (
        .a  (op_a.man),
        .b  (op_b.man),
        .gt (man_gt),
        .eq (man_eq)
    );

    // Stage 1
    logic s1_valid;
    logic s1_nonfinite, s1_zero_exp, s1_sign_a, s1_sign_b;
    logic s1_exp_gt, s1_exp_eq, s1_man_gt, s1_man_eq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: payload registers carry no reset; only the valid bit qualifies them,
    // so stale contents during a bubble or after reset are never observed.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            s1_nonfinite <= nonfinite;
            s1_zero_exp  <= zero_exp;
            s1_sign_a    <= op_a.sign;
            s1_sign_b    <= op_b.sign;
            s1_exp_gt    <= exp_gt;
            s1_exp_eq    <= exp_eq;
            s1_man_gt    <= man_gt;
            s1_man_eq    <= man_eq;
        end
    end

    // Priority resolution
    logic res_eq, res_lt, res_gt;
    logic a_mag_gt;

    assign a_mag_gt = s1_exp_gt | (s1_exp_eq & s1_man_gt);

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        res_eq = 1'b0;
        res_lt = 1'b0;
        res_gt = 1'b0;
        if (s1_nonfinite) begin
            res_eq = 1'b1;
            res_lt = 1'b1;
            res_gt = 1'b1;
        end else if (s1_zero_exp) begin
            res_eq = 1'b0;
        end else if ((s1_sign_a == s1_sign_b) && s1_exp_eq && s1_man_eq) begin
            res_eq = 1'b1;
        end else if (s1_sign_a != s1_sign_b) begin
            res_lt = s1_sign_a;
            res_gt = ~s1_sign_a;
        end else begin
            // Same sign: a negative sign inverts the magnitude ordering.
            res_gt = a_mag_gt ^ s1_sign_a;
            res_lt = ~(a_mag_gt ^ s1_sign_a);
        end
    end

    // Stage 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            equal_to     <= 1'b0;
            less_than    <= 1'b0;
            greater_than <= 1'b0;
        end else begin
            out_valid    <= s1_valid;
            equal_to     <= s1_valid & res_eq;
            less_than    <= s1_valid & res_lt;
            greater_than <= s1_valid & res_gt;
        end
    end

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench for comparator: directed vector table, pipeline and
// reset sequences, then random operands against a real-valued reference model.
module tb_comparator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] A_64 = '0;
    logic [63:0] B_64 = '0;
    logic        out_valid, equal_to, less_than, greater_than;

    comparator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .A_64         (A_64),
        .B_64         (B_64),
        .out_valid    (out_valid),
        .equal_to     (equal_to),
        .less_than    (less_than),
        .greater_than (greater_than)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act !== req) $display("FAIL %s: got %0h expected %0h", name, act, req);
        else pass_cnt++;
    endtask

    // {eq, lt, gt}, derived from the numeric values rather than bit fields.
    function automatic logic [2:0] ref_flags(input logic [63:0] a, input logic [63:0] b);
        real ra, rb;
        if (a[62:52] == 11'h7FF || b[62:52] == 11'h7FF) return 3'b111;
        if (a[62:52] == 11'h000 || b[62:52] == 11'h000) return 3'b000;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        if (ra == rb) return 3'b100;
        return (ra < rb) ? 3'b010 : 3'b001;
    endfunction

    typedef struct {
        string       name;
        logic [2:0]  flags;
        int          due;
    } pend_t;

    pend_t exp_q[$];

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  flags;
    } vec_t;

    vec_t vecs[12];

    // Scoreboard: every result must appear exactly two cycles after issue.
    always @(negedge clk) begin
        if (rst_n) begin
            pend_t p;
            logic  want_valid;
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                p = exp_q.pop_front();
                check({p.name, " missing"}, 64'd0, 64'd1);
            end
            want_valid = (exp_q.size() > 0 && exp_q[0].due == cyc);
            check("out_valid", {63'd0, out_valid}, {63'd0, want_valid});
            if (want_valid) begin
                p = exp_q.pop_front();
                check(p.name, {61'd0, equal_to, less_than, greater_than}, {61'd0, p.flags});
            end else begin
                check("idle_flags", {61'd0, equal_to, less_than, greater_than}, 64'd0);
            end
        end
    end

    task automatic send(input string name, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] f);
        pend_t p;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        A_64 = a;
        B_64 = b;
        p.name  = name;
        p.flags = f;
        p.due   = cyc + 2;
        exp_q.push_back(p);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            A_64 = {$urandom, $urandom};
            B_64 = {$urandom, $urandom};
        end
    endtask

    function automatic logic [63:0] rand_op();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 9))
            0: v[62:52] = 11'h7FF;
            1: v[62:52] = 11'h000;
            2: v[62:52] = 11'h001;
            3: v[62:52] = 11'h7FE;
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [63:0] rand_partner(input logic [63:0] a);
        logic [63:0] b;
        b = a;
        case ($urandom_range(0, 6))
            0: ;
            1: b[0] = ~b[0];
            2: b[51:0] = {$urandom, $urandom};
            3: b[63] = ~b[63];
            4: b[62:52] = a[62:52] + 11'd1;
            5: b[62:52] = a[62:52] - 11'd1;
            default: b = rand_op();
        endcase
        return b;
    endfunction

    initial begin
        vecs[0]  = '{"eq_pos",    64'h401599999999999A, 64'h401599999999999A, 3'b100};
        vecs[1]  = '{"eq_neg",    64'hC01599999999999A, 64'hC01599999999999A, 3'b100};
        vecs[2]  = '{"gt_pos",    64'h401CCCCCCCCCCCCD, 64'h4019333333333333, 3'b001};
        vecs[3]  = '{"gt_neg",    64'hC019333333333333, 64'hC01CCCCCCCCCCCCD, 3'b001};
        vecs[4]  = '{"lt_pos",    64'h4020333333333333, 64'h4022000000000000, 3'b010};
        vecs[5]  = '{"lt_neg",    64'hC022000000000000, 64'hC020333333333333, 3'b010};
        vecs[6]  = '{"lt_sign",   64'hBFF0000000000000, 64'h3FF0000000000000, 3'b010};
        vecs[7]  = '{"zero_zero", 64'h0000000000000000, 64'h0000000000000000, 3'b000};
        vecs[8]  = '{"zero_negz", 64'h0000000000000000, 64'h8000000000000000, 3'b000};
        vecs[9]  = '{"nan_one",   64'h7FF8000000000000, 64'h3FF0000000000000, 3'b111};
        vecs[10] = '{"inf_inf",   64'h7FF0000000000000, 64'h7FF0000000000000, 3'b111};
        vecs[11] = '{"gt_sign",   64'h3FF0000000000000, 64'hBFF0000000000000, 3'b001};

        // Reset state
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_flags", {61'd0, equal_to, less_than, greater_than}, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Directed table, streamed back-to-back
        foreach (vecs[i]) send(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].flags);
        idle(3);

        // Bubbles between operations must appear as out_valid gaps
        send("gap_a", vecs[2].a, vecs[2].b, vecs[2].flags);
        idle(1);
        send("gap_b", vecs[4].a, vecs[4].b, vecs[4].flags);
        idle(2);
        send("gap_c", vecs[0].a, vecs[0].b, vecs[0].flags);
        idle(4);

        // Asynchronous reset mid-stream discards in-flight work
        send("pre_rst_0", vecs[2].a, vecs[2].b, vecs[2].flags);
        send("pre_rst_1", vecs[5].a, vecs[5].b, vecs[5].flags);
        send("pre_rst_2", vecs[9].a, vecs[9].b, vecs[9].flags);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_flags", {61'd0, equal_to, less_than, greater_than}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(4);
        send("post_rst", vecs[3].a, vecs[3].b, vecs[3].flags);
        idle(3);

        // Random operands against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [63:0] a, b;
            a = rand_op();
            b = rand_partner(a);
            if ($urandom_range(0, 7) == 0) idle(1);
            send("rand", a, b, ref_flags(a, b));
        end
        idle(1);

        // Drain with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
